mem_req_arbiter: RTL

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_pkg.sv | 34 +++
 rtl/mem_req_arbiter_owner_fifo.sv | 56 +++++
 rtl/mem_req_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared encodings for the instruction/data memory request arbiter:
// FSM state codes, transaction owner IDs and the downstream command bundle.
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOCK_I = 2'b01,
    ST_LOCK_D = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  // Free-choice winner: data has priority unless a waiting inst is starved.
  function automatic owner_e idle_winner(input logic inst_req,
                                         input logic data_req,
                                         input logic starved);
    if (starved)       return OWNER_INST;
    else if (data_req) return OWNER_DATA;
    else if (inst_req) return OWNER_INST;
    else               return OWNER_DATA;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_owner_fifo.sv
// Owner FIFO: remembers which requester each accepted transaction belongs to
// so that responses can be steered back in acceptance order.
module owner_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int OT_DEPTH = 4
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   push,
  input  owner_e push_owner,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output owner_e head
);

  localparam int PTR_W = $clog2(OT_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(OT_DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  owner_e           slots [OT_DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Owner storage; contents are only meaningful between push and pop, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_owner;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbiter merging an instruction and a data SRAM-like requester onto one
// downstream memory port. Selection is combinational in IDLE; a request that
// is presented but not accepted locks the port to its owner until accepted.
// An owner FIFO routes data_ok/rdata back in acceptance order.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int OT_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        err_stray_data_ok
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state;
  logic [CNT_W-1:0] starve_cnt;
  owner_e           winner;
  logic             any_req;
  logic             starved;
  logic             accept;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  owner_e           fifo_head;
  mem_cmd_t         inst_cmd;
  mem_cmd_t         data_cmd;
  mem_cmd_t         sel_cmd;

  assign inst_cmd = '{wr: inst_sram_wr, size: inst_sram_size, wstrb: inst_sram_wstrb,
                      addr: inst_sram_addr, wdata: inst_sram_wdata};
  assign data_cmd = '{wr: data_sram_wr, size: data_sram_size, wstrb: data_sram_wstrb,
                      addr: data_sram_addr, wdata: data_sram_wdata};

  // Pick the current owner of the downstream port: locked owner, or a fresh choice in IDLE.
  always_comb begin
    starved = inst_sram_req && (starve_cnt == LIMIT);
    winner  = OWNER_DATA;
    any_req = 1'b0;
    case (state)
      ST_LOCK_I: begin
        winner  = OWNER_INST;
        any_req = inst_sram_req;
      end
      ST_LOCK_D: begin
        winner  = OWNER_DATA;
        any_req = data_sram_req;
      end
      default: begin
        winner  = idle_winner(inst_sram_req, data_sram_req, starved);
        any_req = inst_sram_req || data_sram_req;
      end
    endcase
  end

  // A full owner FIFO blocks new requests; reset silences the downstream port.
  assign mem_req = resetn && any_req && !fifo_full;
  assign accept  = mem_req && mem_addr_ok;
  assign sel_cmd = (winner == OWNER_INST) ? inst_cmd : data_cmd;

  assign mem_wr    = resetn ? sel_cmd.wr    : 1'b0;
  assign mem_size  = resetn ? sel_cmd.size  : 2'b00;
  assign mem_wstrb = resetn ? sel_cmd.wstrb : 4'h0;
  assign mem_addr  = resetn ? sel_cmd.addr  : 32'h0;
  assign mem_wdata = resetn ? sel_cmd.wdata : 32'h0;

  assign inst_sram_addr_ok = accept && (winner == OWNER_INST);
  assign data_sram_addr_ok = accept && (winner == OWNER_DATA);

  // Responses: the FIFO head names the owner of the returning beat.
  assign pop               = mem_data_ok && !fifo_empty;
  assign inst_sram_data_ok = pop && (fifo_head == OWNER_INST);
  assign data_sram_data_ok = pop && (fifo_head == OWNER_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  owner_fifo #(
    .OT_DEPTH (OT_DEPTH)
  ) u_owner_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_owner (winner),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  // Lock FSM: hold the port for a requester whose request was not accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else if (!fifo_full) begin
      case (state)
        ST_IDLE: begin
          if (mem_req && !mem_addr_ok)
            state <= (winner == OWNER_INST) ? ST_LOCK_I : ST_LOCK_D;
        end
        ST_LOCK_I, ST_LOCK_D: begin
          if (accept || !any_req) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Count data grants made while inst waits; saturates at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!inst_sram_req) begin
      starve_cnt <= '0;
    end else if (accept) begin
      if (winner == OWNER_INST)    starve_cnt <= '0;
      else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_stray_data_ok <= 1'b0;
    end else if (mem_data_ok && fifo_empty) begin
      err_stray_data_ok <= 1'b1;
    end
  end

endmodule
